// File: rtl/snac_port_scanner.sv
// SNAC user-port scanner: synchronizes the raw port, scans one or two native
// controllers through the shared select line and registers per-player buttons.
module snac_port_scanner #(
   parameter int SETTLE_CYCLES = 32,
   parameter int SAMPLE_COUNT  = 4
) (
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic       enable,
   input  logic       two_player,
   input  logic       swap,
   input  logic [7:0] user_in,
   output logic [7:0] user_out,
   output logic [2:0] user_mode,
   output logic [4:0] joy_a,
   output logic [4:0] joy_b,
   output logic [1:0] pad_a,
   output logic [1:0] pad_b,
   output logic       upd_a,
   output logic       upd_b
);

   localparam int CNT_W = $clog2(SETTLE_CYCLES + 16);
   localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_COUNT - 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SINGLE  = 3'd1,
      ST_SETTLE1 = 3'd2,
      ST_SAMPLE1 = 3'd3,
      ST_SETTLE2 = 3'd4,
      ST_SAMPLE2 = 3'd5
   } state_t;

   // Player word layout: {pad[1], pad[0], joy[4:0]}.
   function automatic logic [6:0] map_word(input logic [7:0] s);
      return {s[2], s[1], s[3], s[5], s[7], s[1], s[2]};
   endfunction

   function automatic logic [7:0] drive_word(input logic sel);
      return {3'b111, sel, 4'b1111};
   endfunction

   function automatic state_t entry_state(input logic [1:0] mode);
      case (mode)
         2'b10:   return ST_SINGLE;
         2'b11:   return ST_SETTLE1;
         default: return ST_IDLE;
      endcase
   endfunction

   logic [7:0]       sync_meta_r;
   logic [7:0]       sync_r;
   logic [7:0]       cap_r;
   logic             match_r;
   logic [1:0]       mode_r;
   logic [1:0]       mode_s;
   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic [6:0]       p1_r;
   logic [6:0]       p2_r;
   logic             upd1_r;
   logic             upd2_r;
   logic             window_ok_s;

   assign mode_s = {enable, two_player};

   // Two-flop synchronizer for the asynchronous port pins.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         sync_meta_r <= 8'hFF;
         sync_r      <= 8'hFF;
      end else begin
         sync_meta_r <= user_in;
         sync_r      <= sync_meta_r;
      end
   end

   // A window is clean when every sample after the captured one matched it.
   always_comb begin
      window_ok_s = 1'b0;
      if (cnt_r == CNT_ZERO) begin
         window_ok_s = 1'b1;
      end else begin
         window_ok_s = match_r && (sync_r == cap_r);
      end
   end

   // Scan state machine with registered port drive and player registers.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_r   <= ST_IDLE;
         mode_r    <= 2'b00;
         cnt_r     <= CNT_ZERO;
         cap_r     <= 8'hFF;
         match_r   <= 1'b0;
         p1_r      <= 7'd0;
         p2_r      <= 7'd0;
         upd1_r    <= 1'b0;
         upd2_r    <= 1'b0;
         user_out  <= 8'hFF;
         user_mode <= 3'b000;
      end else begin
         upd1_r <= 1'b0;
         upd2_r <= 1'b0;
         if (mode_s != mode_r) begin
            mode_r    <= mode_s;
            state_r   <= entry_state(mode_s);
            cnt_r     <= CNT_ZERO;
            match_r   <= 1'b0;
            p1_r      <= 7'd0;
            p2_r      <= 7'd0;
            user_out  <= drive_word(1'b1);
            user_mode <= (mode_s == 2'b11) ? 3'b100 : 3'b000;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  p1_r <= 7'd0;
                  p2_r <= 7'd0;
               end
               ST_SINGLE: begin
                  p1_r   <= map_word(sync_r);
                  p2_r   <= 7'd0;
                  upd1_r <= (map_word(sync_r) != p1_r);
               end
               ST_SETTLE1, ST_SETTLE2: begin
                  if (cnt_r == SETTLE_LAST) begin
                     cnt_r   <= CNT_ZERO;
                     state_r <= (state_r == ST_SETTLE1) ? ST_SAMPLE1 : ST_SAMPLE2;
                  end else begin
                     cnt_r <= cnt_r + CNT_ONE;
                  end
               end
               ST_SAMPLE1, ST_SAMPLE2: begin
                  if (cnt_r == CNT_ZERO) begin
                     cap_r   <= sync_r;
                     match_r <= 1'b1;
                  end else if (sync_r != cap_r) begin
                     match_r <= 1'b0;
                  end
                  if (cnt_r == SAMPLE_LAST) begin
                     cnt_r <= CNT_ZERO;
                     // On a clean window sync_r equals the captured value.
                     if (window_ok_s && (state_r == ST_SAMPLE1)) begin
                        p1_r   <= map_word(sync_r);
                        upd1_r <= 1'b1;
                     end else if (window_ok_s) begin
                        p2_r   <= map_word(sync_r);
                        upd2_r <= 1'b1;
                     end
                     state_r  <= (state_r == ST_SAMPLE1) ? ST_SETTLE2 : ST_SETTLE1;
                     user_out <= drive_word(state_r == ST_SAMPLE2);
                  end else begin
                     cnt_r <= cnt_r + CNT_ONE;
                  end
               end
               default: begin
                  state_r <= ST_IDLE;
               end
            endcase
         end
      end
   end

   // Output register with player swap.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         joy_a <= 5'd0;
         joy_b <= 5'd0;
         pad_a <= 2'd0;
         pad_b <= 2'd0;
         upd_a <= 1'b0;
         upd_b <= 1'b0;
      end else if (swap) begin
         joy_a <= p2_r[4:0];
         pad_a <= p2_r[6:5];
         upd_a <= upd2_r;
         joy_b <= p1_r[4:0];
         pad_b <= p1_r[6:5];
         upd_b <= upd1_r;
      end else begin
         joy_a <= p1_r[4:0];
         pad_a <= p1_r[6:5];
         upd_a <= upd1_r;
         joy_b <= p2_r[4:0];
         pad_b <= p2_r[6:5];
         upd_b <= upd2_r;
      end
   end

endmodule

// File: tb/tb_snac_port_scanner.sv
// Scoreboard bench for snac_port_scanner: expected player words are queued
// with the stimulus and checked whenever an upd pulse appears.
module tb_snac_port_scanner;

   logic       clk_sys = 1'b0;
   logic       reset_n;
   logic       enable;
   logic       two_player;
   logic       swap;
   logic [7:0] user_in;
   logic [7:0] user_out;
   logic [2:0] user_mode;
   logic [4:0] joy_a;
   logic [4:0] joy_b;
   logic [1:0] pad_a;
   logic [1:0] pad_b;
   logic       upd_a;
   logic       upd_b;

   localparam logic [6:0] W_8C = {2'b10, 5'b10101};
   localparam logic [6:0] W_22 = {2'b01, 5'b01010};

   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   int         last_a_cyc = -1;
   bit         auto_drive = 1'b0;
   logic [7:0] glitch_mask = 8'h00;
   logic [6:0] q_a[$];
   logic [6:0] q_b[$];

   snac_port_scanner dut (
      .clk_sys    (clk_sys),
      .reset_n    (reset_n),
      .enable     (enable),
      .two_player (two_player),
      .swap       (swap),
      .user_in    (user_in),
      .user_out   (user_out),
      .user_mode  (user_mode),
      .joy_a      (joy_a),
      .joy_b      (joy_b),
      .pad_a      (pad_a),
      .pad_b      (pad_b),
      .upd_a      (upd_a),
      .upd_b      (upd_b)
   );

   always #5 clk_sys = ~clk_sys;

   // One cycle: drive the port from the select line, then score upd pulses.
   task automatic step();
      logic [6:0] exp_w;
      @(negedge clk_sys);
      cyc++;
      if (auto_drive) user_in = (user_out[4] ? 8'h8C : 8'h22) ^ glitch_mask;
      if (upd_a === 1'b1) begin
         checks++;
         last_a_cyc = cyc;
         if (q_a.size() == 0) begin
            failures++;
            $display("FAIL sb_upd_a cycle=%0d got unexpected pulse word=%b required=no pulse", cyc, {pad_a, joy_a});
         end else begin
            exp_w = q_a.pop_front();
            if ({pad_a, joy_a} !== exp_w) begin
               failures++;
               $display("FAIL sb_word_a cycle=%0d got=%b required=%b", cyc, {pad_a, joy_a}, exp_w);
            end
         end
      end
      if (upd_b === 1'b1) begin
         checks++;
         if (q_b.size() == 0) begin
            failures++;
            $display("FAIL sb_upd_b cycle=%0d got unexpected pulse word=%b required=no pulse", cyc, {pad_b, joy_b});
         end else begin
            exp_w = q_b.pop_front();
            if ({pad_b, joy_b} !== exp_w) begin
               failures++;
               $display("FAIL sb_word_b cycle=%0d got=%b required=%b", cyc, {pad_b, joy_b}, exp_w);
            end
         end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; enable = 1'b0; two_player = 1'b0; swap = 1'b0; user_in = 8'h8C;
      repeat (3) step();
      checks++;
      if ({user_out, user_mode} !== {8'hFF, 3'b000}) begin
         failures++;
         $display("FAIL reset_port got=%h/%b required=ff/000", user_out, user_mode);
      end
      checks++;
      if ({joy_a, joy_b, pad_a, pad_b, upd_a, upd_b} !== 16'd0) begin
         failures++;
         $display("FAIL reset_outputs got=%b required=0", {joy_a, joy_b, pad_a, pad_b, upd_a, upd_b});
      end
      reset_n = 1'b1;
      repeat (5) step();
      checks++;
      if ({user_out, user_mode, joy_a, joy_b, pad_a, pad_b} !== {8'hFF, 3'b000, 14'd0}) begin
         failures++;
         $display("FAIL idle_outputs got=%h/%b/%b required=ff/000/0", user_out, user_mode, {joy_a, joy_b, pad_a, pad_b});
      end
   endtask

   task automatic test_single();
      enable = 1'b1;
      q_a.push_back(W_8C);
      repeat (5) step();
      checks++;
      if ({pad_a, joy_a, pad_b, joy_b} !== {W_8C, 7'd0}) begin
         failures++;
         $display("FAIL single_words got=%b/%b required=%b/0", {pad_a, joy_a}, {pad_b, joy_b}, W_8C);
      end
      checks++;
      if (user_mode !== 3'b000) begin
         failures++;
         $display("FAIL single_mode got=%b required=000", user_mode);
      end
      // Four-cycle input-to-output latency.
      user_in = 8'h22;
      q_a.push_back(W_22);
      repeat (3) step();
      checks++;
      if ({pad_a, joy_a} !== W_8C) begin
         failures++;
         $display("FAIL single_latency_early got=%b required=%b", {pad_a, joy_a}, W_8C);
      end
      step();
      checks++;
      if ({pad_a, joy_a} !== W_22) begin
         failures++;
         $display("FAIL single_latency got=%b required=%b", {pad_a, joy_a}, W_22);
      end
      user_in = 8'h8C;
      q_a.push_back(W_8C);
      repeat (6) step();
      swap = 1'b1;
      step();
      checks++;
      if ({pad_b, joy_b, pad_a, joy_a} !== {W_8C, 7'd0}) begin
         failures++;
         $display("FAIL single_swap got=%b/%b required=%b/0", {pad_b, joy_b}, {pad_a, joy_a}, W_8C);
      end
      swap = 1'b0;
      repeat (2) step();
      checks++;
      if (q_a.size() != 0) begin
         failures++;
         $display("FAIL single_pulses got=%0d pending required=0", q_a.size());
      end
   endtask

   task automatic test_two_player();
      int start;
      int first_a;
      int first_b;
      int falls;
      int bad_port;
      logic prev_sel;
      first_a = -1; first_b = -1; falls = 0; bad_port = 0;
      auto_drive = 1'b1;
      two_player = 1'b1;
      start = cyc;
      prev_sel = user_out[4];
      q_a.push_back(W_8C); q_a.push_back(W_8C);
      q_b.push_back(W_22); q_b.push_back(W_22);
      for (int i = 0; i < 150; i++) begin
         step();
         if (upd_a === 1'b1 && first_a < 0) first_a = cyc;
         if (upd_b === 1'b1 && first_b < 0) first_b = cyc;
         if (prev_sel === 1'b1 && user_out[4] === 1'b0) falls++;
         prev_sel = user_out[4];
         if (!(user_out === 8'hFF || user_out === 8'hEF) || user_mode !== 3'b100) bad_port++;
      end
      checks++;
      if (bad_port != 0) begin
         failures++;
         $display("FAIL scan_port got=%0d bad cycles required=0", bad_port);
      end
      checks++;
      if (falls != 2) begin
         failures++;
         $display("FAIL scan_select got=%0d select drops required=2", falls);
      end
      // Entry clock + settle + sample window + output register.
      checks++;
      if (first_a - start != 1 + 32 + 4 + 1) begin
         failures++;
         $display("FAIL scan_first_a got=%0d required=38", first_a - start);
      end
      checks++;
      if (first_b - first_a != 36) begin
         failures++;
         $display("FAIL scan_spacing got=%0d required=36", first_b - first_a);
      end
      checks++;
      if ({pad_a, joy_a, pad_b, joy_b} !== {W_8C, W_22}) begin
         failures++;
         $display("FAIL scan_words got=%b/%b required=%b/%b", {pad_a, joy_a}, {pad_b, joy_b}, W_8C, W_22);
      end
      checks++;
      if (q_a.size() + q_b.size() != 0) begin
         failures++;
         $display("FAIL scan_pulses got=%0d pending required=0", q_a.size() + q_b.size());
      end
   endtask

   task automatic test_glitch();
      int rise;
      logic prev_sel;
      rise = -1;
      q_a.push_back(W_8C); q_a.push_back(W_8C);
      q_b.push_back(W_22); q_b.push_back(W_22);
      for (int i = 0; i < 100 && rise < 0; i++) begin
         prev_sel = user_out[4];
         step();
         if (prev_sel === 1'b0 && user_out[4] === 1'b1) rise = cyc;
      end
      checks++;
      if (rise < 0) begin
         failures++;
         $display("FAIL glitch_find_settle1 got=timeout required=select rise");
      end
      // Glitch lands on the second sample of the SAMPLE1 window.
      for (int k = 1; k <= 110; k++) begin
         glitch_mask = (k == 31) ? 8'h08 : 8'h00;
         step();
      end
      glitch_mask = 8'h00;
      checks++;
      if (last_a_cyc - rise != 109) begin
         failures++;
         $display("FAIL glitch_next_commit got=%0d required=109", last_a_cyc - rise);
      end
      checks++;
      if (q_a.size() + q_b.size() != 0) begin
         failures++;
         $display("FAIL glitch_pulses got=%0d pending required=0", q_a.size() + q_b.size());
      end
   endtask

   task automatic test_abort();
      int fall;
      logic prev_sel;
      fall = -1;
      q_b.push_back(W_22);
      q_a.push_back(W_8C);
      for (int i = 0; i < 100 && fall < 0; i++) begin
         prev_sel = user_out[4];
         step();
         if (prev_sel === 1'b1 && user_out[4] === 1'b0) fall = cyc;
      end
      checks++;
      if (fall < 0) begin
         failures++;
         $display("FAIL abort_find_settle2 got=timeout required=select drop");
      end
      repeat (33) step();
      two_player = 1'b0;
      // Pipeline still holds two player-2 samples when SINGLE starts.
      q_a.push_back(W_22);
      q_a.push_back(W_8C);
      step();
      checks++;
      if ({user_out, user_mode} !== {8'hFF, 3'b000}) begin
         failures++;
         $display("FAIL abort_port got=%h/%b required=ff/000", user_out, user_mode);
      end
      step();
      checks++;
      if ({pad_b, joy_b} !== 7'd0) begin
         failures++;
         $display("FAIL abort_clear_b got=%b required=0", {pad_b, joy_b});
      end
      repeat (40) step();
      checks++;
      if ({pad_a, joy_a} !== W_8C) begin
         failures++;
         $display("FAIL abort_single_a got=%b required=%b", {pad_a, joy_a}, W_8C);
      end
      checks++;
      if (q_a.size() + q_b.size() != 0) begin
         failures++;
         $display("FAIL abort_pulses got=%0d pending required=0", q_a.size() + q_b.size());
      end
   endtask

   task automatic test_reset_mid();
      int rise;
      int start;
      logic prev_sel;
      rise = -1;
      two_player = 1'b1;
      q_a.push_back(W_8C);
      q_b.push_back(W_22);
      for (int i = 0; i < 120 && rise < 0; i++) begin
         prev_sel = user_out[4];
         step();
         if (prev_sel === 1'b0 && user_out[4] === 1'b1) rise = cyc;
      end
      checks++;
      if (rise < 0) begin
         failures++;
         $display("FAIL rstmid_find_settle1 got=timeout required=select rise");
      end
      repeat (16) step();
      checks++;
      if (joy_a !== 5'b10101) begin
         failures++;
         $display("FAIL rstmid_pre got=%b required=10101", joy_a);
      end
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({user_out, user_mode, joy_a, joy_b, pad_a, pad_b, upd_a, upd_b} !== {8'hFF, 3'b000, 16'd0}) begin
         failures++;
         $display("FAIL rstmid_async got=%h/%b/%b required=ff/000/0", user_out, user_mode, {joy_a, joy_b, pad_a, pad_b, upd_a, upd_b});
      end
      repeat (3) step();
      reset_n = 1'b1;
      start = cyc;
      last_a_cyc = -1;
      q_a.push_back(W_8C);
      for (int i = 0; i < 100 && last_a_cyc < 0; i++) step();
      checks++;
      if (last_a_cyc - start != 1 + 32 + 4 + 1) begin
         failures++;
         $display("FAIL rstmid_first_a got=%0d required=38", last_a_cyc - start);
      end
      checks++;
      if (q_a.size() != 0) begin
         failures++;
         $display("FAIL rstmid_pulses got=%0d pending required=0", q_a.size());
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_two_player();
      test_glitch();
      test_abort();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/snac_port_scanner.md
Name: snac_port_scanner

Overview:
- Sequences the shared open-drain user port for SNAC (native Atari controller) input.
- Single-player mode: samples one controller continuously.
- Two-player mode: time-multiplexes two controllers on one port through a select line. Each player is given a settle window and then a debounced sample window.
- Outputs are registered, per-player joystick and paddle-button bits, which the top level muxes onto the console joystick and paddle inputs.

Parameters:
- SETTLE_CYCLES, 32, clk_sys cycles to wait after the select line changes before sampling starts (minimum 4).
- SAMPLE_COUNT, 4, number of consecutive synchronized samples that must match before they are committed (range 1..15).

Ports:
- clk_sys  in  1  system clock; all logic is in this domain.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  SNAC serial mode on.
- two_player  in  1  1 = multiplexed two-player scan, 0 = single controller.
- swap  in  1  exchange player A and player B outputs.
- user_in  in  8  raw user port inputs, asynchronous.
- user_out  out  8  user port drive value.
- user_mode  out  3  user port mode.
- joy_a  out  5  player A joystick {fire, up, down, left, right}, raw port polarity.
- joy_b  out  5  player B joystick, same format.
- pad_a  out  2  player A paddle buttons {right, left}.
- pad_b  out  2  player B paddle buttons.
- upd_a  out  1  one-cycle pulse when player A registers are committed.
- upd_b  out  1  one-cycle pulse when player B registers are committed.

Behaviour:
Reset values:
- user_out = 8'hFF, user_mode = 3'b000.
- joy_a, joy_b, pad_a, pad_b = 0.
- upd_a, upd_b = 0.
- State = IDLE, counters = 0, synchronizer = 8'hFF.

Input synchronizer and bit mapping:
- user_in passes through a 2-flop synchronizer (sync). Every sample below is taken from sync.
- Bit mapping from sync to a 5-bit joy word:
  - joy[0] = sync[2], joy[1] = sync[1], joy[2] = sync[7], joy[3] = sync[5], joy[4] = sync[3].
- Paddle word: pad[0] = sync[1], pad[1] = sync[2].

Mode and state selection:
- Mode is decoded as {enable, two_player}.
- Any change of the decoded mode takes effect on the next cycle:
  - the state machine jumps to the mode's entry state;
  - counters clear;
  - internal player registers P1 and P2 clear to 0.
- IDLE (enable = 0):
  - user_out = FF, user_mode = 000;
  - P1 and P2 are held at 0; no upd pulses.
- SINGLE (enable = 1, two_player = 0):
  - user_out = FF, user_mode = 000;
  - P1 is loaded from sync every cycle; P2 = 0;
  - upd for player A (after swap) pulses each cycle that P1 changes.
  - Input-to-output latency is 4 cycles: 2 sync, 1 P1 load, 1 output register.

Two-player scan (enable = 1, two_player = 1):
- user_mode = 3'b100.
- user_out = {3'b111, sel, 4'b1111}, where sel = 1 while player 1 is selected.
- State cycle: SETTLE1 -> SAMPLE1 -> SETTLE2 -> SAMPLE2 -> SETTLE1.
  - SETTLE1 and SAMPLE1 drive sel = 1. SETTLE2 and SAMPLE2 drive sel = 0.
- SETTLEn: count SETTLE_CYCLES cycles, then go to SAMPLEn.
- SAMPLEn: capture sync on the first cycle, then compare over SAMPLE_COUNT cycles in total.
  - All equal: commit the mapped word to Pn and pulse updn on the cycle after the last sample.
  - Any mismatch: Pn is held and there is no pulse.
  - In both cases go to SETTLE of the other player.
- Scan period = 2 × (SETTLE_CYCLES + SAMPLE_COUNT) cycles; 72 cycles with the defaults.

Output register:
- Updated every cycle:
  - joy_a/pad_a = swap ? P2 : P1;
  - joy_b/pad_b = swap ? P1 : P2.
- upd_a and upd_b follow the same swap mapping.
- A swap toggle is visible 1 cycle later and does not disturb the scan.

Reset mid-operation:
- Asserting reset_n low immediately forces all reset values. There is no partial commit.
- After release, the block enters the state of the current mode on the first clock.

Test Plan:
1. Reset with user_in = 8'h8C -> user_out = FF, user_mode = 0, all outputs 0. Release with enable = 0 -> outputs stay 0.
2. enable = 1, two_player = 0, user_in = 8'h8C -> after 4 cycles joy_a = 5'b10101, pad_a = 2'b10, joy_b = 0, one upd_a pulse. Set swap = 1 -> 1 cycle later joy_b = 5'b10101, joy_a = 0.
3. Two-player mode, with the bench driving user_in = 8'h8C when user_out[4] = 1 and 8'h22 when 0 -> by cycle 150 joy_a = 5'b10101, pad_a = 2'b10, joy_b = 5'b01010, pad_b = 2'b01. upd_a and upd_b pulse alternately, spaced 36 cycles apart. user_out alternates between 8'hFF and 8'hEF with user_mode = 3'b100.
4. Two-player mode, glitch user_in bit 3 for 1 cycle in the middle of SAMPLE1 -> P1 is not updated in that window and there is no upd_a. The next window commits normally.
5. Drop two_player to 0 in the middle of SAMPLE2 -> the next cycle is SINGLE: user_mode = 000, user_out = FF, joy_b cleared, and no upd_b from the aborted window.
6. Assert reset_n in the middle of SETTLE1 with joy_a nonzero -> all outputs return to their reset values asynchronously. After release, the scan restarts at SETTLE1 and the first upd_a arrives 32 + 4 cycles later plus the 1-cycle commit.
